// File: rtl/pipeline_control_stage.sv
// Control-side pipeline registers (D->E->M->W) for the 5-stage RV32I core.
// Also handles branch resolution, load-use stalls, flushes and EX operand forwarding selects.
module pipeline_control_stage #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_reg_write,
    input  logic                  d_mem_write,
    input  logic                  d_branch,
    input  logic                  d_jump,
    input  logic                  d_branch_neg,
    input  logic                  d_alu_src,
    input  logic [1:0]            d_result_src,
    input  logic [ALU_CTRL_W-1:0] d_alu_ctrl,
    input  logic [REG_ADDR_W-1:0] d_rs1,
    input  logic [REG_ADDR_W-1:0] d_rs2,
    input  logic [REG_ADDR_W-1:0] d_rd,
    input  logic                  e_zero,
    output logic [ALU_CTRL_W-1:0] e_alu_ctrl,
    output logic                  e_alu_src,
    output logic [1:0]            e_forward_a,
    output logic [1:0]            e_forward_b,
    output logic                  pc_src,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  m_mem_write,
    output logic [REG_ADDR_W-1:0] m_rd,
    output logic                  w_reg_write,
    output logic [1:0]            w_result_src,
    output logic [REG_ADDR_W-1:0] w_rd
);

    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  branch_neg;
        logic                  alu_src;
        logic [1:0]            result_src;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } e_ctrl_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_write;
        logic [1:0]            result_src;
        logic [REG_ADDR_W-1:0] rd;
    } m_ctrl_t;

    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic [REG_ADDR_W-1:0] rd;
    } w_ctrl_t;

    e_ctrl_t d_word;
    e_ctrl_t e_q;
    m_ctrl_t m_q;
    w_ctrl_t w_q;

    logic branch_taken;
    logic lw_stall;
    logic flush_e;

    always_comb begin
        d_word            = '0;
        d_word.reg_write  = d_reg_write;
        d_word.mem_write  = d_mem_write;
        d_word.branch     = d_branch;
        d_word.jump       = d_jump;
        d_word.branch_neg = d_branch_neg;
        d_word.alu_src    = d_alu_src;
        d_word.result_src = d_result_src;
        d_word.alu_ctrl   = d_alu_ctrl;
        d_word.rs1        = d_rs1;
        d_word.rs2        = d_rs2;
        d_word.rd         = d_rd;
    end

    // D->E register: a flush or load-use stall inserts a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
        end else if (flush_e) begin
            e_q <= '0;
        end else begin
            e_q <= d_word;
        end
    end

    // E->M and M->W always advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= '0;
            w_q <= '0;
        end else begin
            m_q.reg_write  <= e_q.reg_write;
            m_q.mem_write  <= e_q.mem_write;
            m_q.result_src <= e_q.result_src;
            m_q.rd         <= e_q.rd;
            w_q.reg_write  <= m_q.reg_write;
            w_q.result_src <= m_q.result_src;
            w_q.rd         <= m_q.rd;
        end
    end

    // Branch resolution, hazard detection; a redirect overrides any stall.
    always_comb begin
        branch_taken = e_q.branch & (e_q.branch_neg ? e_zero : ~e_zero);
        pc_src       = e_q.jump | branch_taken;
        lw_stall     = (e_q.result_src == RES_MEM) && (e_q.rd != '0)
                       && ((e_q.rd == d_rs1) || (e_q.rd == d_rs2));
        stall_f      = lw_stall & ~pc_src;
        stall_d      = lw_stall & ~pc_src;
        flush_d      = pc_src;
        flush_e      = pc_src | lw_stall;
    end

    // Operand forwarding: MEM has priority over WB, x0 never forwards.
    always_comb begin
        e_forward_a = FWD_NONE;
        e_forward_b = FWD_NONE;
        if (m_q.reg_write && (m_q.rd != '0) && (m_q.rd == e_q.rs1)) begin
            e_forward_a = FWD_MEM;
        end else if (w_q.reg_write && (w_q.rd != '0) && (w_q.rd == e_q.rs1)) begin
            e_forward_a = FWD_WB;
        end
        if (m_q.reg_write && (m_q.rd != '0) && (m_q.rd == e_q.rs2)) begin
            e_forward_b = FWD_MEM;
        end else if (w_q.reg_write && (w_q.rd != '0) && (w_q.rd == e_q.rs2)) begin
            e_forward_b = FWD_WB;
        end
    end

    assign e_alu_ctrl   = e_q.alu_ctrl;
    assign e_alu_src    = e_q.alu_src;
    assign m_mem_write  = m_q.mem_write;
    assign m_rd         = m_q.rd;
    assign w_reg_write  = w_q.reg_write;
    assign w_result_src = w_q.result_src;
    assign w_rd         = w_q.rd;

endmodule

// File: tb/tb_pipeline_control_stage.sv
// Directed bench for pipeline_control_stage: reset, load-use, forwarding,
// branch/jump flushes and stall-vs-redirect priority.
module tb_pipeline_control_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_reg_write, d_mem_write, d_branch, d_jump, d_branch_neg, d_alu_src;
    logic [1:0] d_result_src;
    logic [2:0] d_alu_ctrl;
    logic [4:0] d_rs1, d_rs2, d_rd;
    logic       e_zero;
    logic [2:0] e_alu_ctrl;
    logic       e_alu_src;
    logic [1:0] e_forward_a, e_forward_b;
    logic       pc_src, stall_f, stall_d, flush_d, m_mem_write;
    logic [4:0] m_rd;
    logic       w_reg_write;
    logic [1:0] w_result_src;
    logic [4:0] w_rd;
    logic [25:0] all_outs;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_control_stage #(.REG_ADDR_W(5), .ALU_CTRL_W(3)) dut (
        .clk(clk), .rst(rst),
        .d_reg_write(d_reg_write), .d_mem_write(d_mem_write), .d_branch(d_branch),
        .d_jump(d_jump), .d_branch_neg(d_branch_neg), .d_alu_src(d_alu_src),
        .d_result_src(d_result_src), .d_alu_ctrl(d_alu_ctrl),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .e_zero(e_zero),
        .e_alu_ctrl(e_alu_ctrl), .e_alu_src(e_alu_src),
        .e_forward_a(e_forward_a), .e_forward_b(e_forward_b),
        .pc_src(pc_src), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .m_mem_write(m_mem_write), .m_rd(m_rd),
        .w_reg_write(w_reg_write), .w_result_src(w_result_src), .w_rd(w_rd)
    );

    always #5 clk = ~clk;

    assign all_outs = {e_alu_ctrl, e_alu_src, e_forward_a, e_forward_b, pc_src, stall_f,
                       stall_d, flush_d, m_mem_write, m_rd, w_reg_write, w_result_src, w_rd};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_d(input logic rw, input logic mw, input logic br, input logic jp,
                           input logic bn, input logic as, input logic [1:0] rs,
                           input logic [2:0] ac, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd);
        d_reg_write = rw; d_mem_write = mw; d_branch = br; d_jump = jp;
        d_branch_neg = bn; d_alu_src = as; d_result_src = rs; d_alu_ctrl = ac;
        d_rs1 = r1; d_rs2 = r2; d_rd = rd;
    endtask

    task automatic nop();
        drive_d(0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        rst    = 1'b1;
        e_zero = 1'b0;
        // store-like word with reg_write, rd=5
        drive_d(1, 1, 0, 0, 0, 1, 2'b00, 3'd3, 5'd1, 5'd2, 5'd5);
        tick(); tick();
        check("rst_hold_outs", 32'(all_outs), 32'd0);

        #2 rst = 1'b0;
        tick(); tick();
        check("pre_rst_m_mem_write", 32'(m_mem_write), 32'd1);
        check("pre_rst_m_rd", 32'(m_rd), 32'd5);
        check("pre_rst_e_alu_ctrl", 32'(e_alu_ctrl), 32'd3);
        #2 rst = 1'b1;
        settle();
        check("rst_async_outs", 32'(all_outs), 32'd0);
        tick();
        check("rst_edge_outs", 32'(all_outs), 32'd0);

        // W latency: add x4 reaches WB on the third edge
        nop();
        #2 rst = 1'b0;
        drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'd2, 5'd1, 5'd2, 5'd4);
        tick(); nop(); settle();
        check("lat1_w_reg_write", 32'(w_reg_write), 32'd0);
        tick();
        check("lat2_w_reg_write", 32'(w_reg_write), 32'd0);
        tick();
        check("lat3_w_reg_write", 32'(w_reg_write), 32'd1);
        check("lat3_w_rd", 32'(w_rd), 32'd4);

        // load-use: lw x5 then add x6, x5, x2
        drain();
        drive_d(1, 0, 0, 0, 0, 1, 2'b01, 3'd0, 5'd1, 5'd0, 5'd5);
        tick();
        drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'd2, 5'd5, 5'd2, 5'd6);
        settle();
        check("lu_stall_f", 32'(stall_f), 32'd1);
        check("lu_stall_d", 32'(stall_d), 32'd1);
        check("lu_flush_d", 32'(flush_d), 32'd0);
        tick();
        check("lu_bubble_alu_ctrl", 32'(e_alu_ctrl), 32'd0);
        check("lu_bubble_alu_src", 32'(e_alu_src), 32'd0);
        check("lu_stall_once", 32'(stall_f), 32'd0);
        tick();
        check("lu_add_in_e", 32'(e_alu_ctrl), 32'd2);
        check("lu_fwd_a", 32'(e_forward_a), 32'd1);
        check("lu_fwd_b", 32'(e_forward_b), 32'd0);

        // forward priority: add x3, sub x3, or x8, x4, x3
        drain();
        drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'd0, 5'd1, 5'd2, 5'd3); tick();
        drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'd1, 5'd1, 5'd2, 5'd3); tick();
        drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'd3, 5'd4, 5'd3, 5'd8); tick();
        check("fwd_b_mem_prio", 32'(e_forward_b), 32'd2);
        check("fwd_a_none", 32'(e_forward_a), 32'd0);
        // WB-only match
        drain();
        drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'd0, 5'd1, 5'd2, 5'd3); tick();
        nop(); tick();
        drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'd3, 5'd4, 5'd3, 5'd8); tick();
        check("fwd_b_wb", 32'(e_forward_b), 32'd1);
        // x0 destinations never forward
        drain();
        drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'd0, 5'd1, 5'd2, 5'd0); tick();
        drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'd1, 5'd1, 5'd2, 5'd0); tick();
        drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'd3, 5'd0, 5'd0, 5'd8); tick();
        check("fwd_b_x0", 32'(e_forward_b), 32'd0);
        check("fwd_a_x0", 32'(e_forward_a), 32'd0);

        // branch polarity: branch_neg=0 takes on zero=0
        drain();
        drive_d(0, 0, 1, 0, 0, 0, 2'b00, 3'd1, 5'd1, 5'd2, 5'd0); tick();
        drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'd2, 5'd1, 5'd2, 5'd9);
        e_zero = 1'b0; settle();
        check("br_taken_pc_src", 32'(pc_src), 32'd1);
        check("br_taken_flush_d", 32'(flush_d), 32'd1);
        check("br_taken_no_stall", 32'(stall_f), 32'd0);
        tick();
        check("br_taken_e_bubble", 32'(e_alu_ctrl), 32'd0);
        check("br_bubble_pc_src", 32'(pc_src), 32'd0);
        drive_d(0, 0, 1, 0, 0, 0, 2'b00, 3'd1, 5'd1, 5'd2, 5'd0); tick();
        drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'd2, 5'd1, 5'd2, 5'd9);
        e_zero = 1'b1; settle();
        check("br_not_taken_pc_src", 32'(pc_src), 32'd0);
        check("br_not_taken_flush_d", 32'(flush_d), 32'd0);
        tick();
        check("br_not_taken_e_next", 32'(e_alu_ctrl), 32'd2);
        drive_d(0, 0, 1, 0, 1, 0, 2'b00, 3'd1, 5'd1, 5'd2, 5'd0); tick();
        nop(); e_zero = 1'b1; settle();
        check("br_neg_zero1_pc_src", 32'(pc_src), 32'd1);
        e_zero = 1'b0; settle();
        check("br_neg_zero0_pc_src", 32'(pc_src), 32'd0);

        // jump: jal x1
        drain();
        drive_d(1, 0, 0, 1, 0, 0, 2'b10, 3'd0, 5'd0, 5'd0, 5'd1); tick();
        nop(); e_zero = 1'b1; settle();
        check("jal_pc_src_z1", 32'(pc_src), 32'd1);
        e_zero = 1'b0; settle();
        check("jal_pc_src_z0", 32'(pc_src), 32'd1);
        tick(); tick();
        check("jal_w_reg_write", 32'(w_reg_write), 32'd1);
        check("jal_w_rd", 32'(w_rd), 32'd1);
        check("jal_w_result_src", 32'(w_result_src), 32'd2);

        // lw x7 then dependent beq that resolves taken
        drain();
        drive_d(1, 0, 0, 0, 0, 1, 2'b01, 3'd0, 5'd1, 5'd0, 5'd7); tick();
        drive_d(0, 0, 1, 0, 0, 0, 2'b00, 3'd1, 5'd7, 5'd0, 5'd0);
        e_zero = 1'b0; settle();
        check("lwbr_stall", 32'(stall_d), 32'd1);
        check("lwbr_no_redirect", 32'(pc_src), 32'd0);
        tick();
        check("lwbr_stall_once", 32'(stall_f), 32'd0);
        check("lwbr_m_mem_write_a", 32'(m_mem_write), 32'd0);
        tick();
        drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'd2, 5'd1, 5'd2, 5'd9); settle();
        check("lwbr_pc_src", 32'(pc_src), 32'd1);
        check("lwbr_flush_d", 32'(flush_d), 32'd1);
        check("lwbr_fwd_a", 32'(e_forward_a), 32'd1);
        tick();
        check("lwbr_e_flushed", 32'(e_alu_ctrl), 32'd0);
        check("lwbr_m_mem_write_b", 32'(m_mem_write), 32'd0);

        // redirect beats load-use stall when both are raised
        drain();
        drive_d(1, 0, 0, 1, 0, 0, 2'b01, 3'd5, 5'd0, 5'd0, 5'd7); tick();
        drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'd2, 5'd7, 5'd0, 5'd9); settle();
        check("prio_pc_src", 32'(pc_src), 32'd1);
        check("prio_stall_f", 32'(stall_f), 32'd0);
        check("prio_stall_d", 32'(stall_d), 32'd0);
        check("prio_flush_d", 32'(flush_d), 32'd1);
        tick();
        check("prio_e_flushed", 32'(e_alu_ctrl), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_control_stage.md
Name: pipeline_control_stage

Overview:
- Carries the decoded control word from the decode (D) stage through the EX, MEM and WB pipeline registers of the 5-stage RV32I core.
- Resolves branches and jumps in EX and produces pc_src.
- Detects load-use hazards and generates the stall and flush controls.
- Generates the EX-stage operand forwarding selects.
- Sits directly downstream of the decode-stage control unit and consumes its outputs every cycle.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- ALU_CTRL_W, 3, width of alu_ctrl.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- d_reg_write, d_mem_write, d_branch, d_jump, d_branch_neg, d_alu_src  in  1 each  decoded control from D stage.
- d_result_src  in  2  00 ALU, 01 memory, 10 PC+4.
- d_alu_ctrl  in  ALU_CTRL_W  decoded ALU operation.
- d_rs1, d_rs2, d_rd  in  REG_ADDR_W each  D-stage register addresses.
- e_zero  in  1  ALU zero flag of the instruction currently in EX.
- e_alu_ctrl  out  ALU_CTRL_W  EX-stage ALU operation.
- e_alu_src  out  1  EX-stage ALU operand-B select.
- e_forward_a, e_forward_b  out  2 each  00 regfile, 01 WB result, 10 MEM ALU result.
- pc_src  out  1  select branch/jump target.
- stall_f, stall_d  out  1 each  hold PC and the IF/ID register.
- flush_d  out  1  bubble the IF/ID register.
- m_mem_write  out  1  MEM-stage store enable.
- m_rd  out  REG_ADDR_W  MEM-stage destination register.
- w_reg_write  out  1  WB-stage register-file write enable.
- w_result_src  out  2  WB-stage result select.
- w_rd  out  REG_ADDR_W  WB-stage destination register.

Behaviour:
- Three control registers (D→E, E→M, M→W), all asynchronously cleared by rst.
  - Cleared state is a bubble: every control bit 0, alu_ctrl 0, result_src 00, rd/rs 0.
  - All outputs are 0 while rst is high and on the first edge after release.
- D→E register:
  - On each rising edge, loads the d_* signals, including d_rs1/d_rs2/d_rd.
  - When flush_e = pc_src | lw_stall, loads a bubble instead.
- E→M and M→W registers: advance unconditionally every cycle; they are never stalled or flushed.
- Branch resolution (combinational from the E register):
  - branch_taken = e_branch & (e_branch_neg ? e_zero : !e_zero).
  - pc_src = e_jump | branch_taken.
  - Zero-cycle latency from e_zero to pc_src.
- Load-use hazard: lw_stall = (e_result_src == 01) & (e_rd != 0) & ((e_rd == d_rs1) | (e_rd == d_rs2)).
  - stall_f = stall_d = lw_stall.
  - Net effect is one bubble; the dependent instruction re-enters D→E on the next edge.
- flush_d = pc_src.
- Simultaneous lw_stall and pc_src cannot occur (EX holds either a load or a branch/jump).
  - Priority is still defined: pc_src wins. stall_f/stall_d are forced to 0 when pc_src = 1, and both D and E are flushed.
- Forwarding, shown for A; B is identical using e_rs2:
  - 10 if m_reg_write & (m_rd != 0) & (m_rd == e_rs1).
  - else 01 if w_reg_write & (w_rd != 0) & (w_rd == e_rs1).
  - else 00.
  - MEM takes priority over WB when both match.
- Register x0 never triggers a stall or a forward.
- Reset asserted mid-pipeline: all in-flight control is discarded immediately (asynchronous). No write or store may occur on the edge coinciding with rst.

Test Plan:
- Reset: assert rst mid-stream with d_reg_write=1, d_mem_write=1 → all outputs 0 at once. After release, w_reg_write first rises 3 edges after a valid D word is presented.
- Load-use: lw x5 (result_src=01, rd=5), then add with rs1=5 → stall_f=stall_d=1 for exactly 1 cycle. E receives a bubble. In the following cycle, e_forward_a=01 for the add.
- Forward priority: add x3 then sub x3, then or with rs2=3 → e_forward_b=10 (MEM beats WB). With rd=0 in place of x3 → e_forward_b=00.
- Branch polarity: e_branch=1, e_branch_neg=0, e_zero=0 → pc_src=1, flush_d=1, next E is a bubble. With e_zero=1 → pc_src=0, no flush.
- Jump: e_jump=1, result_src=10, rd=1 → pc_src=1 regardless of e_zero. The jump itself continues to W with w_reg_write=1, w_rd=1, w_result_src=10.
- Load followed by taken branch dependence: lw x7 in EX while D holds a beq with rs1=7, then branch resolves taken → exactly 1 stall cycle, then pc_src=1 flushes D and E. No spurious m_mem_write.
